// File: rtl/frame_range_pkg.sv
// Shared types and constants for the frame min/max statistics block.
// Holds the line-count default, counter width helper, per-lane result struct
// and the reset value for the range output.
package frame_range_pkg;

  // Default number of lines per frame
  localparam int LINES_DEFAULT = 720;

  // Widest sample a lane can carry; lanes zero-extend into the struct fields
  localparam int LANE_W_MAX = 16;

  // Range output after reset: all ones, so "no frame yet" reads as a full range
  localparam logic [LANE_W_MAX-1:0] DIFF_RESET = '1;

  // Line counter width; a one-line frame still needs a one-bit counter
  function automatic int line_cnt_w(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  // Per-channel published result
  typedef struct packed {
    logic [LANE_W_MAX-1:0] mn;
    logic [LANE_W_MAX-1:0] mx;
    logic [LANE_W_MAX-1:0] diff;
  } lane_out_t;

endpackage

// File: rtl/frame_range_stats_if.sv
// Pixel stream in, frame statistics out, for frame_range_stats.
// master = stream source / stats consumer, slave = the statistics block.
// No back-pressure: every valid beat is consumed.
interface frame_range_stats_if #(
  parameter int W  = 8,
  parameter int CH = 3
);
  logic            sop;
  logic            eop;
  logic            valid;
  logic [CH*W-1:0] data;
  logic [CH*W-1:0] min;
  logic [CH*W-1:0] max;
  logic [CH*W-1:0] max_min_diff;
  logic            stat_valid;

  modport master (output sop, eop, valid, data,
                  input  min, max, max_min_diff, stat_valid);
  modport slave  (input  sop, eop, valid, data,
                  output min, max, max_min_diff, stat_valid);
endinterface

// File: rtl/frame_range_lane.sv
// One channel: min/max accumulators, last-pixel merge, optional IIR, output regs.
// Latency: outputs update on the edge after publish_i; accepts every beat.
// Smoothing compiled in with FRAME_RANGE_SMOOTH_EN (shift SMOOTH_SHIFT, 1..4).
module frame_range_lane
  import frame_range_pkg::*;
#(
  parameter int W            = 8,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] sample_i,
  input  logic         beat_i,
  input  logic         load_i,
  input  logic         publish_i,
  output lane_out_t    lane_o
);

  logic [W-1:0] min_acc_q, max_acc_q;
  logic [W-1:0] raw_mn, raw_mx;
  logic [W-1:0] mn_q, mx_q, diff_q;
  logic [W-1:0] mn_d, mx_d;

  // Merge of accumulator and current beat; a frame start reloads from the sample.
  // This is both the accumulator next state and the raw frame result.
  always_comb begin
    raw_mn = sample_i;
    raw_mx = sample_i;
    if (!load_i) begin
      raw_mn = (sample_i < min_acc_q) ? sample_i : min_acc_q;
      raw_mx = (sample_i > max_acc_q) ? sample_i : max_acc_q;
    end
  end

  // Accumulators track every valid beat; their reset value is irrelevant
  // because nothing is published before a frame start reloads them
  always_ff @(posedge clk) begin
    if (beat_i) begin
      min_acc_q <= raw_mn;
      max_acc_q <= raw_mx;
    end
  end

`ifdef FRAME_RANGE_SMOOTH_EN
  logic first_q;

  // out + ((raw - out) >>> shift), signed in W+1 bits; result stays between out and raw
  function automatic logic [W-1:0] iir(input logic [W-1:0] cur, input logic [W-1:0] raw);
    logic signed [W:0] delta;
    delta = $signed({1'b0, raw}) - $signed({1'b0, cur});
    delta = delta >>> SMOOTH_SHIFT;
    return cur + delta[W-1:0];
  endfunction

  // First frame after reset loads raw values, later frames are filtered
  always_comb begin
    mn_d = first_q ? raw_mn : iir(mn_q, raw_mn);
    mx_d = first_q ? raw_mx : iir(mx_q, raw_mx);
  end

  // Tracks whether any frame has been published since reset
  always_ff @(posedge clk) begin
    if (!reset_n)       first_q <= 1'b1;
    else if (publish_i) first_q <= 1'b0;
  end
`else
  // Unfiltered: publish the raw frame result
  always_comb begin
    mn_d = raw_mn;
    mx_d = raw_mx;
  end
`endif

  // Output registers hold until the next published frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mn_q   <= '0;
      mx_q   <= '0;
      diff_q <= DIFF_RESET[W-1:0];
    end else if (publish_i) begin
      mn_q   <= mn_d;
      mx_q   <= mx_d;
      diff_q <= mx_d - mn_d;
    end
  end

  assign lane_o.mn   = LANE_W_MAX'(mn_q);
  assign lane_o.mx   = LANE_W_MAX'(mx_q);
  assign lane_o.diff = LANE_W_MAX'(diff_q);

endmodule

// File: rtl/frame_range_stats.sv
// Per-channel frame min/max/range over LINES lines, published with a 1-cycle strobe.
// Latency: 1 cycle after the frame-end beat. No back-pressure; valid=0 beats ignored.
// Optional temporal smoothing of published values with FRAME_RANGE_SMOOTH_EN.
module frame_range_stats
  import frame_range_pkg::*;
#(
  parameter int W            = 8,
  parameter int CH           = 3,
  parameter int LINES        = LINES_DEFAULT,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  frame_range_stats_if.slave    bus
);

  localparam int             LCW       = line_cnt_w(LINES);
  localparam logic [LCW-1:0] LAST_LINE = LCW'(LINES - 1);

  logic [LCW-1:0] line_cnt_q, line_cnt_d;
  logic           armed_q, armed_d;
  logic           stat_valid_q;
  logic           line_end, frame_start, frame_end, publish;

  // Event decode plus line counter / armed next state. With LINES==1 start and
  // end can share a beat; that beat publishes even though armed is still clear.
  always_comb begin
    line_end    = bus.valid && bus.eop;
    frame_start = bus.valid && bus.sop && (line_cnt_q == '0);
    frame_end   = line_end && (line_cnt_q == LAST_LINE);
    publish     = frame_end && (armed_q || frame_start);
    line_cnt_d  = line_cnt_q;
    if (line_end) line_cnt_d = frame_end ? '0 : line_cnt_q + LCW'(1);
    armed_d = armed_q;
    if (frame_end)        armed_d = 1'b0;
    else if (frame_start) armed_d = 1'b1;
  end

  // Frame tracking state and the publish strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_cnt_q   <= '0;
      armed_q      <= 1'b0;
      stat_valid_q <= 1'b0;
    end else begin
      line_cnt_q   <= line_cnt_d;
      armed_q      <= armed_d;
      stat_valid_q <= publish;
    end
  end

  lane_out_t lane_out [CH];

  for (genvar c = 0; c < CH; c++) begin : g_lane
    frame_range_lane #(
      .W            (W),
      .SMOOTH_SHIFT (SMOOTH_SHIFT)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .sample_i  (bus.data[c*W +: W]),
      .beat_i    (bus.valid),
      .load_i    (frame_start),
      .publish_i (publish),
      .lane_o    (lane_out[c])
    );
    assign bus.min[c*W +: W]          = lane_out[c].mn[W-1:0];
    assign bus.max[c*W +: W]          = lane_out[c].mx[W-1:0];
    assign bus.max_min_diff[c*W +: W] = lane_out[c].diff[W-1:0];
  end

  assign bus.stat_valid = stat_valid_q;

endmodule

// File: tb/tb_frame_range_stats.sv
// Directed bench for frame_range_stats (W=8, CH=3, LINES=4, 4 pixels per line).
// Expected frame results are computed while driving and queued; the monitor pops
// them when stat_valid fires and checks values and the one-cycle latency.
module tb_frame_range_stats;
  localparam int W     = 8;
  localparam int CH    = 3;
  localparam int LINES = 4;
  localparam int PPL   = 4;

  typedef struct {
    int              cyc;
    logic [CH*W-1:0] mn;
    logic [CH*W-1:0] mx;
    logic [CH*W-1:0] df;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t last_exp;
  exp_t mon_e;
  bit   prev_sv = 1'b0;

`ifdef FRAME_RANGE_SMOOTH_EN
  logic [W-1:0] sm_mn [CH];
  logic [W-1:0] sm_mx [CH];
  bit           sm_init = 1'b0;

  function automatic logic [W-1:0] smooth(input logic [W-1:0] cur, input logic [W-1:0] raw);
    int d;
    d = int'(raw) - int'(cur);
    d = d >>> 2;
    return W'(int'(cur) + d);
  endfunction
`endif

  frame_range_stats_if #(.W(W), .CH(CH)) bus();

  frame_range_stats #(
    .W            (W),
    .CH           (CH),
    .LINES        (LINES),
    .SMOOTH_SHIFT (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (bus.stat_valid === 1'b1) begin
      chk("stat_valid_pulse_width", {31'b0, prev_sv}, 32'd0);
      chk("stat_valid_expected", {31'b0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("publish_latency", cyc, mon_e.cyc);
        chk("min", 32'(bus.min), 32'(mon_e.mn));
        chk("max", 32'(bus.max), 32'(mon_e.mx));
        chk("max_min_diff", 32'(bus.max_min_diff), 32'(mon_e.df));
      end
    end
    prev_sv = (bus.stat_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pix(input int kind, input int i, input int c);
    int px;
    px = i % PPL;
    case (kind)
      0: return (px == 1) ? 8'h10 : (px == 2) ? 8'hF0 : 8'h40;
      1: begin
        if (c == 0)      return (i == 0) ? 8'h20 : (i == 9) ? 8'h80 : 8'h50;
        else if (c == 1) return (i == 3) ? 8'h00 : (i == 14) ? 8'hFF : W'(i * 16 + 8);
        else             return 8'h55;
      end
      2: return (i == 0) ? 8'hFE : (i == LINES*PPL-1) ? 8'h01 : 8'h80;
      default: return W'(8'h30 + i);
    endcase
  endfunction

  task automatic beat(input logic s, input logic e, input logic v, input logic [CH*W-1:0] d);
    bus.sop = s; bus.eop = e; bus.valid = v; bus.data = d;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    beat(1'b0, 1'b0, 1'b0, '0);
    reset_n = 1'b1;
`ifdef FRAME_RANGE_SMOOTH_EN
    sm_init = 1'b0;
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_min"}, 32'(bus.min), 32'h0);
    chk({tag, "_max"}, 32'(bus.max), 32'h0);
    chk({tag, "_diff"}, 32'(bus.max_min_diff), 32'hFFFFFF);
    chk({tag, "_stat_valid"}, {31'b0, bus.stat_valid}, 32'd0);
  endtask

  // kind: pixel pattern; pub: frame is expected to publish; rst_at: pixel index
  // before which reset is pulsed (-1 for none). Kind 3 inserts valid=0 garbage beats.
  task automatic send_frame(input int kind, input bit pub, input int rst_at);
    logic [W-1:0]    mn [CH];
    logic [W-1:0]    mx [CH];
    logic [CH*W-1:0] d;
    logic [W-1:0]    v;
    exp_t            e;
    int              i;
    for (int c = 0; c < CH; c++) begin mn[c] = '1; mx[c] = '0; end
    for (int ln = 0; ln < LINES; ln++) begin
      for (int px = 0; px < PPL; px++) begin
        i = ln * PPL + px;
        if (i == rst_at) pulse_reset();
        if (kind == 3 && px == 2) beat(1'b1, 1'b1, 1'b0, (ln % 2 == 1) ? '1 : '0);
        for (int c = 0; c < CH; c++) begin
          v = pix(kind, i, c);
          d[c*W +: W] = v;
          if (v < mn[c]) mn[c] = v;
          if (v > mx[c]) mx[c] = v;
        end
        if (pub && ln == LINES-1 && px == PPL-1) begin
          e.cyc = cyc + 1;
`ifdef FRAME_RANGE_SMOOTH_EN
          for (int c = 0; c < CH; c++) begin
            sm_mn[c] = sm_init ? smooth(sm_mn[c], mn[c]) : mn[c];
            sm_mx[c] = sm_init ? smooth(sm_mx[c], mx[c]) : mx[c];
            mn[c] = sm_mn[c];
            mx[c] = sm_mx[c];
          end
          sm_init = 1'b1;
`endif
          for (int c = 0; c < CH; c++) begin
            e.mn[c*W +: W] = mn[c];
            e.mx[c*W +: W] = mx[c];
            e.df[c*W +: W] = mx[c] - mn[c];
          end
          sb.push_back(e);
          last_exp = e;
        end
        beat(px == 0, px == PPL-1, 1'b1, d);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.sop = 1'b0; bus.eop = 1'b0; bus.valid = 1'b0; bus.data = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("por");

    send_frame(0, 1'b1, -1);   // 0x40 field with 0x10/0xF0 column: 10/F0/E0
    send_frame(1, 1'b1, -1);   // independent channel ranges, B constant
    send_frame(2, 1'b1, -1);   // extremes on first and last pixel
    send_frame(3, 1'b1, -1);   // valid=0 bubbles carrying sop/eop and garbage
    beat(1'b0, 1'b0, 1'b0, '0);
    beat(1'b0, 1'b0, 1'b0, '0);

    send_frame(1, 1'b0, 2);    // reset during line 0; remainder must not publish
    beat(1'b0, 1'b0, 1'b0, '0);
    beat(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk_reset_vals("after_midframe_reset");

    send_frame(2, 1'b1, -1);   // first full frame after reset publishes
    beat(1'b0, 1'b0, 1'b0, '0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("hold_min", 32'(bus.min), 32'(last_exp.mn));
    chk("hold_max", 32'(bus.max), 32'(last_exp.mx));
    chk("hold_diff", 32'(bus.max_min_diff), 32'(last_exp.df));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_range_stats.md
# frame_range_stats

Multi-channel, parametrised frame min/max statistics block for the HDR video pipeline. It sits on the pixel stream after capture and before tone mapping. It tracks the per-channel minimum and maximum of every pixel in a frame of `LINES` lines. On the last pixel of the frame it publishes min, max and range with a one-cycle strobe. Optionally, it temporally smooths these values to suppress flicker in downstream contrast stretching.

## Interface
Parameters:
- `W`, default 8: bits per channel sample.
- `CH`, default 3: number of channels packed in `data`. Channel 0 occupies the LSBs.
- `LINES`, default 720: lines per frame.
- `SMOOTH_SHIFT`, default 2: IIR shift. Used only when smoothing is compiled in. Legal range 1..4.

Ports:
- `clk` in 1: pixel clock.
- `reset_n` in 1: reset. One clock; reset is synchronous and active-low.
- `sop` in 1: start of line. Qualified by `valid`.
- `eop` in 1: end of line. Qualified by `valid`.
- `valid` in 1: beat valid.
- `data` in `CH*W`: packed pixel.
- `min` out `CH*W`: per-channel frame minimum.
- `max` out `CH*W`: per-channel frame maximum.
- `max_min_diff` out `CH*W`: per-channel `max − min`.
- `stat_valid` out 1: one-cycle pulse when the outputs update.

## Operation
- Beats with `valid=0` are ignored entirely, including any `sop`/`eop` asserted on them.
- Line counter `line_cnt` (width `$clog2(LINES)`):
  - Increments on `valid&&eop`.
  - Wraps to 0 on `valid&&eop&&line_cnt==LINES-1`.
- Event definitions:
  - Frame start = `valid&&sop&&line_cnt==0`.
  - Frame end = `valid&&eop&&line_cnt==LINES-1`.
- Accumulation, per channel:
  - On frame start: `min_acc` and `max_acc` load the channel sample.
  - On other valid beats: `min_acc` takes the minimum and `max_acc` takes the maximum, evaluated independently. A sample can update both.
- Flag `armed`:
  - Set on frame start.
  - Cleared on frame end.
  - Cleared by reset.
- Frame end with `armed=1`:
  - The result is the merge of accumulator and current beat: min(`min_acc`, sample) and max(`max_acc`, sample). The last pixel is always included.
  - The result is registered to the outputs, and `stat_valid` pulses.
- Frame end with `armed=0` (reset or stream joined mid-frame): no output update and no `stat_valid`. The accumulators still track, and the next frame start re-arms.
- A frame start while `armed=1` restarts the accumulators (resync). No output is produced for the aborted frame.
- Edge cases:
  - `sop` and `eop` on the same beat (one-pixel line) is legal and counts as both events.
  - `LINES==1` is legal: a one-line frame's start and end may fall on the same beat. Accumulators are loaded, merged and published that beat.
- Arithmetic is unsigned. `max_min_diff = max − min` per channel, is never negative by construction, and needs no saturation.

## Timing
- Latency: `min`, `max`, `max_min_diff` and `stat_valid` are all registered. They change on the clock edge after the frame-end beat, which is 1 cycle of latency.
- Outputs hold their values until the next published frame.
- `stat_valid` is high for exactly one cycle per published frame.
- Reset values:
  - `min`=0, `max`=0.
  - `max_min_diff`=all ones per channel.
  - `stat_valid`=0, `line_cnt`=0, `armed`=0.
  - Accumulators are don't-care.
- Reset mid-frame: the block is idle until the next frame start, and the remainder of the interrupted frame is not published.
- No back-pressure. The block accepts every beat.

## Configuration
- `FRAME_RANGE_SMOOTH_EN` undefined: published min/max equal the raw frame result.
- `FRAME_RANGE_SMOOTH_EN` defined: published values follow `out <= out + ((raw − out) >>> SMOOTH_SHIFT)`.
  - Signed difference with arithmetic shift, computed in W+1 bits.
  - The first published frame after reset loads `raw` directly.
  - `max_min_diff` is computed from the smoothed min/max.
  - Latency and the `stat_valid` timing are unchanged.

## Structure
- Shared package `frame_range_pkg` holds:
  - the `LINES` default;
  - the line counter width function;
  - the per-channel lane output struct (min, max, diff);
  - the `DIFF_RESET` constant (all ones).
- Sub-module `frame_range_lane`:
  - One instance per channel, via a generate loop.
  - Contains the accumulators, merge, optional smoothing and output registers.
- Top level holds `line_cnt`, `armed`, event decode and `stat_valid`.

## Test plan
- `W=8`, `CH=1`, `LINES=4`, 4×4 frame of 0x40 except one 0x10 and one 0xF0 in the same middle pixel positions across lines → min=0x10, max=0xF0, diff=0xE0, one `stat_valid` the cycle after the last `eop`.
- Extreme values on the last pixel (0x01) and the first pixel (0xFE) → min=0x01, max=0xFE. This confirms first-pixel load and last-pixel merge.
- `CH=3`, channels carrying different ranges (R 0x20..0x80, G 0x00..0xFF, B constant 0x55) → per-channel results independent; B diff=0.
- `reset_n` pulsed mid-frame, then the stream continues → no `stat_valid` for that frame. The next full frame publishes correctly. Outputs stay at reset values (0, 0, 0xFF) until then.
- `valid=0` bubbles carrying `eop` and garbage data inside a frame → ignored; results and line count unaffected.
- With `FRAME_RANGE_SMOOTH_EN`, `SMOOTH_SHIFT=2`: frames with max 0x80 then 0xC0 → published max 0x80 then 0x90.
